// File: rtl/sram_array_seq.sv
// DEPTH x WIDTH SRAM array model with a precharge / wordline access sequencer.
// Optional build macro SRAM_SEQ_PARITY_EN adds a stored even-parity bit per word.
module sram_array_seq #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int PRE_CYCLES = 1,
  parameter int WL_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
`ifdef SRAM_SEQ_PARITY_EN
  input  logic              parity_flip,
  output logic              rsp_perr,
`endif
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              pre_n,
  output logic [DEPTH-1:0]  wl,
  output logic              busy
);

  localparam int CNT_MAX = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
`ifdef SRAM_SEQ_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, PRE, WL, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [MEM_W-1:0]   mem [DEPTH];
  logic [MEM_W-1:0]   mem_rd;
  logic [MEM_W-1:0]   wr_word;
  logic               accept, in_range, commit;

  assign accept   = req_valid && req_ready;
  // Widened compare so a power-of-two DEPTH does not wrap to zero.
  assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
  assign commit   = (state_q == WL) && (cnt_q == CNT_W'(WL_CYCLES - 1));

  assign req_ready = (state_q == IDLE) || (state_q == DONE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q == PRE) || (state_q == WL);
  assign pre_n     = (state_q != PRE);
  assign rsp_rdata = rdata_q;

  // Per-wordline decode; an out-of-range address matches no line.
  for (genvar i = 0; i < DEPTH; i++) begin : g_wl
    assign wl[i] = (state_q == WL) && (addr_q == ADDR_W'(i));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = PRE;
        cnt_d   = '0;
      end
      PRE: if (cnt_q == CNT_W'(PRE_CYCLES - 1)) begin
        state_d = WL;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      WL: if (commit) state_d = DONE;
          else        cnt_d   = cnt_q + CNT_W'(1);
      DONE: if (accept) begin
        state_d = PRE;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_rd = in_range ? mem[addr_q] : '0;

`ifdef SRAM_SEQ_PARITY_EN
  logic flip_q;
  logic perr_q, perr_d;

  assign wr_word  = {(^wdata_q) ^ flip_q, wdata_q};
  // Stored parity makes the whole word XOR to zero when intact.
  assign perr_d   = commit ? (!we_q && in_range && (^mem_rd)) : perr_q;
  assign rsp_perr = perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (accept) flip_q <= parity_flip;
      perr_q <= perr_d;
    end
  end
`else
  assign wr_word = wdata_q;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (commit) begin
      if (we_q) rdata_d = in_range ? wdata_q : '0;
      else      rdata_d = mem_rd[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      rdata_q <= rdata_d;
    end
  end

  // Array contents are deliberately not reset; a reset before the commit edge
  // leaves the sequencer in IDLE so the pending write never lands.
  always_ff @(posedge clk) begin
    if (commit && we_q && in_range) mem[addr_q] <= wr_word;
  end

endmodule
